// File: rtl/alarm_pkg.sv
// Shared types for the alarm bank: per-channel FSM state encoding and
// the ring-counter width helper.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_e;

    // Bits needed to count 0..ring_secs, never less than one.
    function automatic int ring_width(input int ring_secs);
        int w;
        w = $clog2(ring_secs + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One egg-timer channel: load/countdown/alarm FSM with registered outputs,
// repeat reload on acknowledge and an optional ring timeout.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int RING_SECS = 30
) (
    input  logic            sec_clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            enable_i,
    input  logic            ack_i,
    input  logic            repeat_i,
    input  logic [SIZE-1:0] max_i,
    output logic [SIZE-1:0] count_o,
    output logic            alarm_o,
    output logic            missed_o
);

    localparam int            RW        = ring_width(RING_SECS);
    localparam logic [RW-1:0] RING_LAST = RW'((RING_SECS == 0) ? 0 : RING_SECS - 1);
    localparam logic [SIZE-1:0] ONE     = SIZE'(1);

    state_e          state_q;
    logic [SIZE-1:0] count_q;
    logic [RW-1:0]   ring_q;
    logic            alarm_q;
    logic            missed_q;

    // NOTE: one clocked block with non-blocking assignments only; reset is
    // synchronous, so it sits inside the edge-triggered branch as highest priority.
    always_ff @(posedge sec_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            ring_q   <= '0;
            alarm_q  <= 1'b0;
            missed_q <= 1'b0;
        end else if (start_i) begin
            count_q  <= max_i;
            ring_q   <= '0;
            missed_q <= 1'b0;
            if (max_i == '0) begin
                state_q <= ALARM;
                alarm_q <= 1'b1;
            end else begin
                state_q <= RUN;
                alarm_q <= 1'b0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (enable_i) begin
                        if (count_q <= ONE) begin
                            count_q <= '0;
                            ring_q  <= '0;
                            state_q <= ALARM;
                            alarm_q <= 1'b1;
                        end else begin
                            count_q <= count_q - ONE;
                        end
                    end
                end
                ALARM: begin
                    if (ack_i) begin
                        ring_q <= '0;
                        if (repeat_i) begin
                            count_q <= max_i;
                            // A zero preset re-arms immediately: keep ringing.
                            if (max_i != '0) begin
                                state_q <= RUN;
                                alarm_q <= 1'b0;
                            end
                        end else begin
                            state_q <= IDLE;
                            alarm_q <= 1'b0;
                        end
                    end else if (RING_SECS != 0 && ring_q == RING_LAST) begin
                        state_q  <= IDLE;
                        alarm_q  <= 1'b0;
                        missed_q <= 1'b1;
                    end else begin
                        ring_q <= ring_q + RW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign count_o  = count_q;
    assign alarm_o  = alarm_q;
    assign missed_o = missed_q;

endmodule

// File: rtl/alarm_bank.sv
// Bank of CHANNELS independent egg-timer channels sharing the one-second
// tick, with a combined "something is ringing" flag.
module alarm_bank #(
    parameter int CHANNELS  = 2,
    parameter int SIZE      = 4,
    parameter int RING_SECS = 30
) (
    input  logic                     sec_clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      start,
    input  logic [CHANNELS-1:0]      enable,
    input  logic [CHANNELS-1:0]      ack,
    input  logic [CHANNELS-1:0]      repeat_mode,
    input  logic [CHANNELS*SIZE-1:0] max,
    output logic [CHANNELS*SIZE-1:0] count,
    output logic [CHANNELS-1:0]      alarm,
    output logic [CHANNELS-1:0]      missed,
    output logic                     any_alarm
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        alarm_channel #(
            .SIZE      (SIZE),
            .RING_SECS (RING_SECS)
        ) u_channel (
            .sec_clk  (sec_clk),
            .rst      (rst),
            .start_i  (start[i]),
            .enable_i (enable[i]),
            .ack_i    (ack[i]),
            .repeat_i (repeat_mode[i]),
            .max_i    (max[i*SIZE +: SIZE]),
            .count_o  (count[i*SIZE +: SIZE]),
            .alarm_o  (alarm[i]),
            .missed_o (missed[i])
        );
    end

    assign any_alarm = |alarm;

endmodule
